// File: rtl/chip_slot_arbiter_if.sv
// Port bundle for the chip-bus slot arbiter: decoder strobes and requests in,
// slot ownership, timebase and CPU handshake out.
interface chip_slot_arbiter_if;
    logic       nCDR;
    logic       nCDW;
    logic       nRGAE;
    logic       nBLS;
    logic       dma_req;
    logic       blt_req;
    logic       blt_nasty;
    logic       nDBR;
    logic       XRDY;
    logic       dma_grant;
    logic       blt_grant;
    logic       cpu_grant;
    logic       reg_cyc;
    logic [7:0] slot_idx;
    logic [1:0] phase;
    logic       refresh;

    modport master (
        output nCDR, nCDW, nRGAE, nBLS, dma_req, blt_req, blt_nasty,
        input  nDBR, XRDY, dma_grant, blt_grant, cpu_grant, reg_cyc, slot_idx, phase, refresh
    );

    modport slave (
        input  nCDR, nCDW, nRGAE, nBLS, dma_req, blt_req, blt_nasty,
        output nDBR, XRDY, dma_grant, blt_grant, cpu_grant, reg_cyc, slot_idx, phase, refresh
    );
endinterface

// File: rtl/chip_slot_arbiter.sv
// Chip-bus slot sequencer: 4-cycle slots granted to fixed DMA, CPU or blitter, with CPU XRDY handshake.
// Define CHIP_SLOT_REFRESH_EN to reserve slots 0..3 of every line for refresh.
//
// state | meaning
// IDLE  | no CPU chip cycle outstanding
// WAIT  | CPU strobe seen, waiting to win a slot
// CYC   | CPU owns the current slot
// DONE  | XRDY high, waiting for the strobes to release
module chip_slot_arbiter #(
    parameter int HSLOTS    = 227,
    parameter int BLT_YIELD = 3
) (
    input logic                C14M,
    input logic                nRESET,
    chip_slot_arbiter_if.slave bus
);
    localparam int            YW        = $clog2(BLT_YIELD + 1);
    localparam logic [YW-1:0] YIELD_MAX = YW'(BLT_YIELD);
    localparam logic [7:0]    LAST_SLOT = 8'(HSLOTS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, CYC, DONE} cpuState_t;

    cpuState_t     cpuState;
    logic [1:0]    phase;
    logic [7:0]    slotIdx;
    logic [7:0]    nextSlot;
    logic [YW-1:0] yieldCnt;
    logic [YW-1:0] yieldNext;
    logic          nDbrQ;
    logic          xrdyQ;
    logic          dmaGrant;
    logic          bltGrant;
    logic          cpuGrant;
    logic          regCyc;
    logic          refreshQ;
    logic          strobe;
    logic          cpuReq;
    logic          refreshNext;
    logic          dmaWin;
    logic          bltWin;
    logic          cpuWin;

    assign nextSlot = (slotIdx == LAST_SLOT) ? 8'd0 : slotIdx + 8'd1;

`ifdef CHIP_SLOT_REFRESH_EN
    assign refreshNext = (nextSlot < 8'd4);
`else
    assign refreshNext = 1'b0;
`endif

    // A strobe still held from a finished cycle must not win another slot.
    assign strobe = ~bus.nCDR | ~bus.nCDW;
    assign cpuReq = strobe && (cpuState == IDLE || cpuState == WAIT);

    always_comb begin
        dmaWin    = 1'b0;
        bltWin    = 1'b0;
        cpuWin    = 1'b0;
        yieldNext = yieldCnt;
        if (!refreshNext) begin
            if (nextSlot[0] && bus.dma_req) begin
                dmaWin = 1'b1;
            end else if (cpuReq && bus.blt_req) begin
                if ((!bus.blt_nasty && yieldCnt == YIELD_MAX) || !bus.nBLS) begin
                    cpuWin = 1'b1;
                end else begin
                    bltWin = 1'b1;
                    if (yieldCnt != YIELD_MAX) yieldNext = yieldCnt + YW'(1);
                end
            end else if (cpuReq) begin
                cpuWin = 1'b1;
            end else if (bus.blt_req) begin
                bltWin = 1'b1;
            end
            if (cpuWin || !cpuReq) yieldNext = '0;
        end
    end

    always_ff @(posedge C14M) begin
        if (!nRESET) begin
            phase    <= 2'd0;
            slotIdx  <= 8'd0;
            nDbrQ    <= 1'b1;
            xrdyQ    <= 1'b0;
            dmaGrant <= 1'b0;
            bltGrant <= 1'b0;
            cpuGrant <= 1'b0;
            regCyc   <= 1'b0;
            refreshQ <= 1'b0;
            yieldCnt <= '0;
            cpuState <= IDLE;
        end else begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) begin
                slotIdx  <= nextSlot;
                dmaGrant <= dmaWin;
                bltGrant <= bltWin;
                cpuGrant <= cpuWin;
                regCyc   <= cpuWin & ~bus.nRGAE;
                refreshQ <= refreshNext;
                nDbrQ    <= ~(dmaWin | bltWin | refreshNext);
                yieldCnt <= yieldNext;
            end

            case (cpuState)
                IDLE, WAIT: begin
                    if (!strobe) cpuState <= IDLE;
                    else if (phase == 2'd3 && cpuWin) cpuState <= CYC;
                    else cpuState <= WAIT;
                end
                CYC: begin
                    if (!strobe) begin
                        cpuState <= IDLE;
                        cpuGrant <= 1'b0;
                        regCyc   <= 1'b0;
                    end else if (phase == 2'd2) begin
                        // Raised one edge early so XRDY is seen during the last cycle of the owned slot.
                        xrdyQ    <= 1'b1;
                        cpuState <= DONE;
                    end
                end
                DONE: begin
                    if (!strobe) begin
                        xrdyQ    <= 1'b0;
                        cpuState <= IDLE;
                    end
                end
                default: cpuState <= IDLE;
            endcase
        end
    end

    assign bus.phase     = phase;
    assign bus.slot_idx  = slotIdx;
    assign bus.nDBR      = nDbrQ;
    assign bus.XRDY      = xrdyQ;
    assign bus.dma_grant = dmaGrant;
    assign bus.blt_grant = bltGrant;
    assign bus.cpu_grant = cpuGrant;
    assign bus.reg_cyc   = regCyc;
    assign bus.refresh   = refreshQ;
endmodule

// File: tb/tb_chip_slot_arbiter.sv
// Bench for chip_slot_arbiter: directed slot scenarios followed by random traffic
// checked against a slot-level ownership model with a simple CPU agent.
module tb_chip_slot_arbiter;
    localparam int HS = 227;
    localparam int BY = 3;
`ifdef CHIP_SLOT_REFRESH_EN
    localparam bit REFRESH_BUILD = 1'b1;
`else
    localparam bit REFRESH_BUILD = 1'b0;
`endif

    logic C14M = 1'b0;
    logic nRESET;

    chip_slot_arbiter_if bus ();

    chip_slot_arbiter #(.HSLOTS(HS), .BLT_YIELD(BY)) dut (
        .C14M   (C14M),
        .nRESET (nRESET),
        .bus    (bus)
    );

    always #5 C14M = ~C14M;

    int checks = 0;
    int errors = 0;

    // slot-level model state
    int curSlot;
    int agent;       // 0 idle, 1 requesting, 2 owns the current slot
    int lostInRow;   // slots the waiting CPU has lost to the blitter in a row
    bit eDma, eBlt, eCpu, eReg, eRef;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h (slot %0d)", tag, obs, exp, curSlot);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge C14M);
        #1;
    endtask

    task automatic clearModel(input int slot, input bit refr);
        curSlot   = slot;
        agent     = 0;
        lostInRow = 0;
        eDma = 1'b0; eBlt = 1'b0; eCpu = 1'b0; eReg = 1'b0; eRef = refr;
    endtask

    // Entered and left at phase 0; checks the current slot, then predicts the next one.
    task automatic runSlot(input bit dma, input bit blt, input bit nasty, input bit nbls,
                           input bit nrgae, input bit wantReq, input bit abortReq);
        int nxt;
        bit cpuAsks;
        bit inRefresh;
        if (agent == 0 && wantReq) begin
            agent = 1;
            if ($urandom_range(0, 1) == 1) bus.nCDR = 1'b0;
            else bus.nCDW = 1'b0;
        end else if (agent == 1 && abortReq) begin
            agent = 0;
            bus.nCDR = 1'b1;
            bus.nCDW = 1'b1;
        end
        bus.dma_req   = dma;
        bus.blt_req   = blt;
        bus.blt_nasty = nasty;
        bus.nBLS      = nbls;
        bus.nRGAE     = nrgae;

        for (int p = 0; p < 4; p++) begin
            chk("phase", 32'(bus.phase), 32'(p));
            chk("slot_idx", 32'(bus.slot_idx), 32'(curSlot));
            chk("dma_grant", 32'(bus.dma_grant), 32'(eDma));
            chk("blt_grant", 32'(bus.blt_grant), 32'(eBlt));
            chk("cpu_grant", 32'(bus.cpu_grant), 32'(eCpu));
            chk("reg_cyc", 32'(bus.reg_cyc), 32'(eReg));
            chk("refresh", 32'(bus.refresh), 32'(eRef));
            chk("nDBR", 32'(bus.nDBR), 32'(!(eDma || eBlt || eRef)));
            chk("XRDY", 32'(bus.XRDY), 32'(eCpu && p == 3));
            if (p < 3) tick(1);
        end

        if (agent == 2) begin
            agent = 0;
            bus.nCDR = 1'b1;
            bus.nCDW = 1'b1;
        end

        nxt       = (curSlot + 1) % HS;
        cpuAsks   = (agent == 1);
        inRefresh = REFRESH_BUILD && (nxt < 4);
        eDma = 1'b0; eBlt = 1'b0; eCpu = 1'b0;
        if (!inRefresh) begin
            if ((nxt % 2) == 1 && dma) eDma = 1'b1;
            else if (cpuAsks && blt) begin
                if (!nbls || (!nasty && lostInRow >= BY)) eCpu = 1'b1;
                else begin
                    eBlt = 1'b1;
                    if (lostInRow < BY) lostInRow++;
                end
            end else if (cpuAsks) eCpu = 1'b1;
            else if (blt) eBlt = 1'b1;
            if (eCpu || !cpuAsks) lostInRow = 0;
        end
        eRef = inRefresh;
        eReg = eCpu && !nrgae;
        if (eCpu) agent = 2;

        tick(1);
        if (curSlot == HS - 1) chk("wrap", 32'(bus.slot_idx), 32'd0);
        curSlot = nxt;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit yieldPat [6];
        yieldPat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        bus.nCDR = 1'b1; bus.nCDW = 1'b1; bus.nRGAE = 1'b1; bus.nBLS = 1'b1;
        bus.dma_req = 1'b0; bus.blt_req = 1'b0; bus.blt_nasty = 1'b0;
        nRESET = 1'b0;
        clearModel(0, 1'b0);
        tick(2);
        nRESET = 1'b1;
        chk("rst0_phase", 32'(bus.phase), 32'd0);
        chk("rst0_slot", 32'(bus.slot_idx), 32'd0);

        // Reset in the middle of a CPU-owned slot
        bus.nCDR = 1'b0;
        tick(5);
`ifndef CHIP_SLOT_REFRESH_EN
        chk("prerst_cpu_grant", 32'(bus.cpu_grant), 32'd1);
`endif
        nRESET = 1'b0;
        tick(3);
        bus.nCDR = 1'b1;
        nRESET = 1'b1;
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_slot", 32'(bus.slot_idx), 32'd0);
        chk("rst_nDBR", 32'(bus.nDBR), 32'd1);
        chk("rst_XRDY", 32'(bus.XRDY), 32'd0);
        chk("rst_grants", 32'({bus.dma_grant, bus.blt_grant, bus.cpu_grant}), 32'd0);
        chk("rst_reg_cyc", 32'(bus.reg_cyc), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("rst_no_xrdy", 32'(bus.XRDY), 32'd0);
        end
        clearModel(2, REFRESH_BUILD);
        runSlot(0, 0, 0, 1, 1, 0, 0);
        runSlot(0, 0, 0, 1, 1, 0, 0);

        // Lone CPU read requested at slot 4 phase 3
        tick(3);
        bus.nCDR = 1'b0;
        tick(1);
        chk("lone_slot", 32'(bus.slot_idx), 32'd5);
        chk("lone_cpu_grant", 32'(bus.cpu_grant), 32'd1);
        chk("lone_nDBR", 32'(bus.nDBR), 32'd1);
        chk("lone_xrdy_early", 32'(bus.XRDY), 32'd0);
        tick(3);
        chk("lone_xrdy", 32'(bus.XRDY), 32'd1);
        tick(1);
        chk("lone_xrdy_hold", 32'(bus.XRDY), 32'd1);
        chk("lone_grant_end", 32'(bus.cpu_grant), 32'd0);
        bus.nCDR = 1'b1;
        tick(1);
        chk("lone_xrdy_release", 32'(bus.XRDY), 32'd0);

        // DMA beats CPU for odd slot 7, CPU takes slot 8 as a register write
        bus.dma_req = 1'b1;
        bus.nCDW = 1'b0;
        bus.nRGAE = 1'b0;
        tick(3);
        chk("dma_slot", 32'(bus.slot_idx), 32'd7);
        chk("dma_grant7", 32'(bus.dma_grant), 32'd1);
        chk("dma_nDBR7", 32'(bus.nDBR), 32'd0);
        chk("dma_cpu7", 32'(bus.cpu_grant), 32'd0);
        bus.dma_req = 1'b0;
        tick(4);
        chk("cpu_slot8", 32'(bus.slot_idx), 32'd8);
        chk("cpu_grant8", 32'(bus.cpu_grant), 32'd1);
        chk("dma_grant8", 32'(bus.dma_grant), 32'd0);
        chk("reg_cyc8", 32'(bus.reg_cyc), 32'd1);
        tick(3);
        chk("xrdy8", 32'(bus.XRDY), 32'd1);
        bus.nCDW = 1'b1;
        bus.nRGAE = 1'b1;
        tick(1);
        chk("xrdy9_low", 32'(bus.XRDY), 32'd0);

        // CPU abandons its granted slot: no XRDY
        bus.nCDR = 1'b0;
        tick(4);
        chk("abort_grant", 32'(bus.cpu_grant), 32'd1);
        tick(1);
        bus.nCDR = 1'b1;
        tick(1);
        chk("abort_xrdy_p2", 32'(bus.XRDY), 32'd0);
        tick(1);
        chk("abort_xrdy_p3", 32'(bus.XRDY), 32'd0);
        tick(1);
        chk("abort_xrdy_next", 32'(bus.XRDY), 32'd0);
        chk("abort_next_grant", 32'(bus.cpu_grant), 32'd0);
        clearModel(11, 1'b0);

        // Polite blitter yields to the CPU every fourth contested slot
        for (int i = 0; i < 6; i++) begin
            runSlot(0, 1, 0, 1, 1, 1, 0);
            chk("yield_cpu", 32'(bus.cpu_grant), 32'(yieldPat[i]));
            chk("yield_blt", 32'(bus.blt_grant), 32'(!yieldPat[i]));
        end

        // Nasty blitter starves the CPU until nBLS drops
        for (int i = 0; i < 10; i++) begin
            runSlot(0, 1, 1, 1, 1, 1, 0);
            chk("nasty_hold", 32'(bus.cpu_grant), 32'd0);
        end
        runSlot(0, 1, 1, 0, 1, 1, 0);
        chk("nbls_cpu_win", 32'(bus.cpu_grant), 32'd1);
        runSlot(0, 0, 0, 1, 1, 0, 0);

        // Random traffic across the line wrap
        for (int i = 0; i < 300; i++) begin
            runSlot($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
